// File: rtl/riscv_dcache.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dcache
// Brief    : Direct-mapped, one-word-per-line, write-through/no-allocate data
//            cache sitting between the LSU and a single-port backing memory.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_dcache #(
   parameter int LINES      = 64,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      srst_n,
   input  logic                      read_req,
   input  logic [DATA_WIDTH/8-1:0]   write_req,
   input  logic [31:0]               addr,
   input  logic [DATA_WIDTH-1:0]     write_data,
   output logic                      dcache_busy,
   output logic                      read_ack,
   output logic                      write_ack,
   output logic                      rdata_val,
   output logic [DATA_WIDTH-1:0]     rdata,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
   output logic [31:0]               mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic                      mem_ack,
   input  logic [DATA_WIDTH-1:0]     mem_rdata
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - IDX_W;
   localparam int NB    = DATA_WIDTH / 8;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_RFILL = 2'd1;
   localparam logic [1:0] c_WTHRU = 2'd2;

   logic [1:0]            r_state;
   logic [LINES-1:0]      r_valid;
   logic [TAG_W-1:0]      r_tag  [LINES];
   logic [DATA_WIDTH-1:0] r_data [LINES];

   logic                  r_rdata_val;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [NB-1:0]         r_mem_wstrb;
   logic [31:0]           r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;

   logic [IDX_W-1:0]      w_idx;
   logic [TAG_W-1:0]      w_tag;
   logic [IDX_W-1:0]      w_fill_idx;
   logic [TAG_W-1:0]      w_fill_tag;
   logic                  w_hit;
   logic                  w_idle;
   logic                  w_rd_hit;
   logic                  w_rd_miss;
   logic                  w_wr_go;
   logic                  w_fill_done;
   logic                  w_wr_done;
   logic [DATA_WIDTH-1:0] w_merged;
   logic                  w_unused;

   assign w_idx       = addr[2 +: IDX_W];
   assign w_tag       = addr[31 -: TAG_W];
   // The outstanding fill target is recovered from the latched memory address.
   assign w_fill_idx  = r_mem_addr[2 +: IDX_W];
   assign w_fill_tag  = r_mem_addr[31 -: TAG_W];
   assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_idle      = (r_state == c_IDLE);
   assign w_rd_hit    = w_idle && read_req && w_hit;
   assign w_rd_miss   = w_idle && read_req && !w_hit;
   assign w_wr_go     = w_idle && !read_req && (|write_req);
   assign w_fill_done = (r_state == c_RFILL) && mem_ack;
   assign w_wr_done   = (r_state == c_WTHRU) && mem_ack;
   assign w_unused    = ^addr[1:0];

   always_comb begin
      w_merged = r_data[w_idx];
      for (int b = 0; b < NB; b++) begin
         if (write_req[b]) begin
            w_merged[8*b +: 8] = write_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_valid <= '0;
      end else if (w_fill_done) begin
         r_valid[w_fill_idx] <= 1'b1;
      end
   end

   // Tag/data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (w_fill_done) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= mem_rdata;
      end else if (w_wr_go && w_hit) begin
         r_data[w_idx] <= w_merged;
      end
   end

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_state     <= c_IDLE;
         r_rdata_val <= 1'b0;
         r_rdata     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_wstrb <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_rdata_val <= w_rd_hit;
         if (w_rd_hit) begin
            r_rdata <= r_data[w_idx];
         end
         case (r_state)
            c_IDLE: begin
               if (w_rd_miss) begin
                  r_state     <= c_RFILL;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_wstrb <= '0;
                  r_mem_addr  <= {addr[31:2], 2'b00};
                  r_mem_wdata <= '0;
               end else if (w_wr_go) begin
                  r_state     <= c_WTHRU;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_wstrb <= write_req;
                  r_mem_addr  <= {addr[31:2], 2'b00};
                  r_mem_wdata <= write_data;
               end
            end
            c_RFILL, c_WTHRU: begin
               if (mem_ack) begin
                  r_state     <= c_IDLE;
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_wstrb <= '0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign dcache_busy = !w_idle;
   assign read_ack    = w_rd_hit;
   assign write_ack   = w_wr_done;
   assign rdata_val   = r_rdata_val;
   assign rdata       = r_rdata;
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_wstrb   = r_mem_wstrb;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_riscv_dcache.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_dcache
// Brief    : Directed scenarios plus randomized LSU/memory traffic for
//            riscv_dcache, compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_dcache;

   localparam int LINES = 64;
   localparam int IDX_W = 6;
   localparam int P_IDLE = 0;
   localparam int P_FILL = 1;
   localparam int P_WT   = 2;

   logic        clk;
   logic        srst_n;
   logic        read_req;
   logic [3:0]  write_req;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        dcache_busy;
   logic        read_ack;
   logic        write_ack;
   logic        rdata_val;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   riscv_dcache #(.LINES(LINES), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .srst_n     (srst_n),
      .read_req   (read_req),
      .write_req  (write_req),
      .addr       (addr),
      .write_data (write_data),
      .dcache_busy(dcache_busy),
      .read_ack   (read_ack),
      .write_ack  (write_ack),
      .rdata_val  (rdata_val),
      .rdata      (rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_wstrb  (mem_wstrb),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: which word each line holds, plus a sparse memory image.
   int          phase;
   bit          m_valid [LINES];
   logic [29:0] m_waddr [LINES];
   logic [31:0] m_data  [LINES];
   logic [31:0] mem [logic [29:0]];

   logic        e_busy, e_read_ack, e_write_ack, e_rdata_val;
   logic        e_mem_req, e_mem_we;
   logic [3:0]  e_mem_wstrb;
   logic [31:0] e_rdata, e_mem_addr, e_mem_wdata;

   int          busy_cnt, lat;
   bit          pend_v;
   logic [31:0] pend_a;
   bit          checking;
   int          n_pass, n_total;

   function automatic logic [31:0] mem_read(input logic [29:0] w);
      if (mem.exists(w)) return mem[w];
      return {w, 2'b00} * 32'h9E37_79B1;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] m;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (old & ~m) | (nw & m);
   endfunction

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 2) % LINES);
   endfunction

   function automatic bit hit(input logic [31:0] a);
      return m_valid[line_of(a)] && (m_waddr[line_of(a)] == a[31:2]);
   endfunction

   function automatic logic [31:0] rand_addr();
      return (32'($urandom_range(0, 3)) << (IDX_W + 2)) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic clear_mem_exp();
      e_mem_req = 0; e_mem_we = 0; e_mem_wstrb = 0; e_mem_addr = 0; e_mem_wdata = 0;
   endtask

   task automatic start_busy();
      busy_cnt = 0;
      lat = $urandom_range(0, 3);
   endtask

   // Apply the effect of the inputs that were present at this rising edge.
   task automatic model_update();
      logic [29:0] w;
      if (!srst_n) begin
         phase = P_IDLE;
         foreach (m_valid[i]) m_valid[i] = 0;
         e_rdata = 0;
         e_rdata_val = 0;
         clear_mem_exp();
         return;
      end
      e_rdata_val = 0;
      if (phase == P_IDLE) begin
         if (read_req) begin
            if (hit(addr)) begin
               e_rdata = m_data[line_of(addr)];
               e_rdata_val = 1;
               if (pend_v && pend_a[31:2] == addr[31:2]) pend_v = 0;
            end else begin
               phase = P_FILL;
               e_mem_req = 1; e_mem_we = 0; e_mem_addr = {addr[31:2], 2'b00};
               pend_v = 1; pend_a = addr;
               start_busy();
            end
         end else if (write_req != 0) begin
            if (hit(addr)) m_data[line_of(addr)] = merge(m_data[line_of(addr)], write_data, write_req);
            phase = P_WT;
            e_mem_req = 1; e_mem_we = 1; e_mem_wstrb = write_req;
            e_mem_addr = {addr[31:2], 2'b00}; e_mem_wdata = write_data;
            start_busy();
         end
      end else if (mem_ack) begin
         w = e_mem_addr[31:2];
         if (phase == P_FILL) begin
            m_valid[line_of(e_mem_addr)] = 1;
            m_waddr[line_of(e_mem_addr)] = w;
            m_data[line_of(e_mem_addr)]  = mem_rdata;
         end else begin
            mem[w] = merge(mem_read(w), e_mem_wdata, e_mem_wstrb);
         end
         phase = P_IDLE;
         clear_mem_exp();
      end else begin
         busy_cnt++;
      end
   endtask

   task automatic step(input logic r, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic k, input logic [31:0] kd,
                       input logic rn);
      @(posedge clk);
      model_update();
      #1;
      read_req = r; write_req = w; addr = a; write_data = d;
      mem_ack = k; mem_rdata = kd; srst_n = rn;
      e_busy      = (phase != P_IDLE);
      e_read_ack  = (phase == P_IDLE) && r && hit(a);
      e_write_ack = (phase == P_WT) && k;
   endtask

   task automatic idle_cyc();
      step(0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1);
   endtask

   task automatic ack_cyc(input logic [31:0] kd);
      step(0, 4'h0, 32'h0, 32'h0, 1, kd, 1);
   endtask

   task automatic rd(input logic [31:0] a);
      step(1, 4'h0, a, 32'h0, 0, 32'h0, 1);
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("busy",      32'(dcache_busy), 32'(e_busy));
         chk("read_ack",  32'(read_ack),    32'(e_read_ack));
         chk("write_ack", 32'(write_ack),   32'(e_write_ack));
         chk("rdata_val", 32'(rdata_val),   32'(e_rdata_val));
         chk("rdata",     rdata,            e_rdata);
         chk("mem_req",   32'(mem_req),     32'(e_mem_req));
         chk("mem_we",    32'(mem_we),      32'(e_mem_we));
         chk("mem_addr",  mem_addr,         e_mem_addr);
         if (!e_mem_req || e_mem_we) begin
            chk("mem_wstrb", 32'(mem_wstrb), 32'(e_mem_wstrb));
            chk("mem_wdata", mem_wdata,      e_mem_wdata);
         end
      end
   end

   initial begin
      logic        r, k, rn;
      logic [3:0]  w;
      logic [31:0] a, d, kd;

      n_pass = 0; n_total = 0; checking = 0;
      phase = P_IDLE; pend_v = 0; pend_a = 0; busy_cnt = 0; lat = 0;
      foreach (m_valid[i]) begin
         m_valid[i] = 0; m_waddr[i] = 0; m_data[i] = 0;
      end
      e_rdata = 0; e_rdata_val = 0; clear_mem_exp();
      e_busy = 0; e_read_ack = 0; e_write_ack = 0;
      srst_n = 0; read_req = 0; write_req = 0; addr = 0; write_data = 0;
      mem_ack = 0; mem_rdata = 0;
      mem[30'h040] = 32'hDEAD_BEEF;
      mem[30'h080] = 32'h1234_5678;

      step(0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0);
      checking = 1;
      idle_cyc();
      @(negedge clk);
      chk("reset_busy", 32'(dcache_busy), 32'd0);
      chk("reset_mem_req", 32'(mem_req), 32'd0);
      chk("reset_rdata", rdata, 32'h0);

      // Cold read, three-cycle memory
      rd(32'h100);
      @(negedge clk); chk("cold_read_ack", 32'(read_ack), 32'd0);
      idle_cyc();
      @(negedge clk);
      chk("cold_mem_req", 32'(mem_req), 32'd1);
      chk("cold_mem_addr", mem_addr, 32'h100);
      chk("cold_mem_we", 32'(mem_we), 32'd0);
      idle_cyc();
      ack_cyc(32'hDEAD_BEEF);
      rd(32'h100);
      @(negedge clk); chk("refetch_ack", 32'(read_ack), 32'd1);
      idle_cyc();
      @(negedge clk);
      chk("refetch_val", 32'(rdata_val), 32'd1);
      chk("refetch_rdata", rdata, 32'hDEAD_BEEF);

      // Warm read
      rd(32'h100);
      @(negedge clk);
      chk("warm_ack", 32'(read_ack), 32'd1);
      chk("warm_no_mem", 32'(mem_req), 32'd0);
      idle_cyc();
      @(negedge clk); chk("warm_val", 32'(rdata_val), 32'd1);

      // Byte store hit, write-through
      step(0, 4'b0010, 32'h101, 32'h5555_5555, 0, 32'h0, 1);
      idle_cyc();
      @(negedge clk);
      chk("st_wstrb", 32'(mem_wstrb), 32'h2);
      chk("st_we", 32'(mem_we), 32'd1);
      chk("st_addr", mem_addr, 32'h100);
      chk("st_wdata", mem_wdata, 32'h5555_5555);
      ack_cyc(32'h0);
      @(negedge clk); chk("st_write_ack", 32'(write_ack), 32'd1);
      rd(32'h100);
      @(negedge clk); chk("st_reread_ack", 32'(read_ack), 32'd1);
      idle_cyc();
      @(negedge clk);
      chk("st_merged", rdata, 32'hDEAD_55EF);
      chk("st_reread_no_mem", 32'(mem_req), 32'd0);

      // Conflict eviction on the same index
      rd(32'h200);
      @(negedge clk); chk("conflict_miss", 32'(read_ack), 32'd0);
      idle_cyc();
      @(negedge clk); chk("conflict_addr", mem_addr, 32'h200);
      ack_cyc(32'h1234_5678);
      rd(32'h200);
      idle_cyc();
      @(negedge clk); chk("conflict_rdata", rdata, 32'h1234_5678);
      rd(32'h100);
      @(negedge clk); chk("evicted_miss", 32'(read_ack), 32'd0);
      idle_cyc();
      ack_cyc(32'hDEAD_55EF);
      rd(32'h100);
      idle_cyc();

      // Store miss: no allocate
      step(0, 4'hF, 32'h400, 32'hA5A5_A5A5, 0, 32'h0, 1);
      idle_cyc();
      @(negedge clk); chk("stmiss_addr", mem_addr, 32'h400);
      ack_cyc(32'h0);
      rd(32'h400);
      @(negedge clk); chk("stmiss_no_alloc", 32'(read_ack), 32'd0);
      idle_cyc();
      ack_cyc(32'hA5A5_A5A5);
      rd(32'h400);
      @(negedge clk); chk("stmiss_fill_hit", 32'(read_ack), 32'd1);
      idle_cyc();
      @(negedge clk); chk("stmiss_rdata", rdata, 32'hA5A5_A5A5);

      // Reset abandons a fill; the late ack is ignored
      rd(32'h100);
      idle_cyc();
      @(negedge clk); chk("rst_fill_busy", 32'(dcache_busy), 32'd1);
      step(0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0);
      ack_cyc(32'h0BAD_0BAD);
      @(negedge clk); chk("rst_idle", 32'(dcache_busy), 32'd0);
      rd(32'h100);
      @(negedge clk); chk("rst_then_miss", 32'(read_ack), 32'd0);
      idle_cyc();
      @(negedge clk); chk("rst_refill_req", 32'(mem_req), 32'd1);
      ack_cyc(32'hDEAD_55EF);
      rd(32'h100);
      idle_cyc();

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         r = 0; w = 0; a = rand_addr(); d = $urandom; k = 0; kd = $urandom; rn = 1;
         if (phase == P_IDLE) begin
            if ($urandom_range(0, 49) == 0) begin
               rn = 0;
            end else begin
               if (pend_v && $urandom_range(0, 3) != 0) begin
                  r = 1; a = pend_a;
               end else begin
                  case ($urandom_range(0, 7))
                     0, 1, 2: r = 1;
                     3: begin r = 1; w = 4'($urandom_range(1, 15)); end
                     4, 5, 6: w = 4'($urandom_range(1, 15));
                     default: ;
                  endcase
               end
               if ($urandom_range(0, 15) == 0) k = 1;
            end
         end else begin
            r = 1'($urandom_range(0, 1));
            w = 4'($urandom_range(0, 15));
            if (busy_cnt >= lat) begin
               k = 1;
               if (phase == P_FILL) kd = mem_read(e_mem_addr[31:2]);
            end
            if ($urandom_range(0, 39) == 0) rn = 0;
         end
         step(r, w, a, d, k, kd, rn);
      end
      idle_cyc();
      @(negedge clk);
      checking = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
